// File: rtl/tdm_demux_pkg.sv
// Shared constants for the TDM demultiplexer: default geometry and FSM encodings.
package tdm_demux_pkg;

   localparam int DEF_CH = 4;
   localparam int DEF_W  = 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/tdm_demux_if.sv
// Time-multiplexed input bus plus the rebuilt per-channel frame outputs.
interface tdm_demux_if
   import tdm_demux_pkg::*;
#(
   parameter int CH = DEF_CH,
   parameter int W  = DEF_W
);
   localparam int CW = $clog2(CH);

   logic            i_valid;
   logic            i_sync;
   logic [W-1:0]    i_data;
   logic [CH*W-1:0] o_ch;
   logic            o_frame_valid;
   logic [CW-1:0]   o_sel;
   logic            o_busy;
   logic            o_err;

   modport master (
      output i_valid, i_sync, i_data,
      input  o_ch, o_frame_valid, o_sel, o_busy, o_err
   );

   modport slave (
      input  i_valid, i_sync, i_data,
      output o_ch, o_frame_valid, o_sel, o_busy, o_err
   );

endinterface

// File: rtl/tdm_demux_ctrl.sv
// Frame-tracking FSM: owns the channel counter, directs shadow writes and
// frame publication, and flags protocol violations.
module tdm_demux_ctrl
   import tdm_demux_pkg::*;
#(
   parameter int CH = DEF_CH,
   localparam int CW = $clog2(CH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          valid_i,
   input  logic          sync_i,
   output logic          wr_en_o,
   output logic [CW-1:0] wr_idx_o,
   output logic          publish_o,
   output logic [CW-1:0] sel_o,
   output logic          busy_o,
   output logic          err_o
);

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          err_q,   err_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;
      wr_en_o   = 1'b0;
      wr_idx_o  = cnt_q;
      publish_o = 1'b0;
      if (valid_i) begin
         if (sync_i) begin
            // A sync always restarts the frame; in RUN it also discards the partial one.
            err_d    = (state_q == ST_RUN);
            wr_en_o  = 1'b1;
            wr_idx_o = '0;
            cnt_d    = CW'(1);
            state_d  = ST_RUN;
         end else if (state_q == ST_IDLE) begin
            err_d = 1'b1;
         end else begin
            wr_en_o = 1'b1;
            if (cnt_q == CW'(CH - 1)) begin
               publish_o = 1'b1;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign sel_o  = cnt_q;
   assign busy_o = (state_q == ST_RUN);
   assign err_o  = err_q;

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer top: shadows incoming channel words and publishes each
// complete frame to the parallel outputs with a one-cycle strobe.
module tdm_demux
   import tdm_demux_pkg::*;
#(
   parameter int CH = DEF_CH,
   parameter int W  = DEF_W,
   localparam int CW = $clog2(CH)
) (
   input  logic       i_clk,
   input  logic       i_rst,
   tdm_demux_if.slave bus
);

   logic          wr_en;
   logic [CW-1:0] wr_idx;
   logic          publish;

   logic [W-1:0]    shadow_q [CH];
   logic [CH*W-1:0] ch_q, ch_d;
   logic            fv_q;

   tdm_demux_ctrl #(.CH(CH)) u_ctrl (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .valid_i   (bus.i_valid),
      .sync_i    (bus.i_sync),
      .wr_en_o   (wr_en),
      .wr_idx_o  (wr_idx),
      .publish_o (publish),
      .sel_o     (bus.o_sel),
      .busy_o    (bus.o_busy),
      .err_o     (bus.o_err)
   );

   // The last channel is taken straight from the bus so the frame publishes on its accepting edge.
   always_comb begin
      ch_d = '0;
      for (int unsigned k = 0; k < CH; k++) begin
         ch_d[k*W +: W] = (k == CH - 1) ? bus.i_data : shadow_q[k];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned k = 0; k < CH; k++) begin
            shadow_q[k] <= '0;
         end
         ch_q <= '0;
         fv_q <= 1'b0;
      end else begin
         if (wr_en) begin
            shadow_q[wr_idx] <= bus.i_data;
         end
         if (publish) begin
            ch_q <= ch_d;
         end
         fv_q <= publish;
      end
   end

   assign bus.o_ch          = ch_q;
   assign bus.o_frame_valid = fv_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based frame model.
module tb_tdm_demux;

   localparam int CH = 4;
   localparam int W  = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tdm_demux_if #(.CH(CH), .W(W)) bus ();

   tdm_demux #(.CH(CH), .W(W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [W-1:0]    part [$];
   bit              in_frame;
   logic [CH*W-1:0] m_ch;
   bit              m_fv;
   bit              m_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      part.delete();
      in_frame = 1'b0;
      m_ch     = '0;
      m_fv     = 1'b0;
      m_err    = 1'b0;
   endtask

   // Frame rules: a sync starts a frame (early if one is open), a plain word
   // outside a frame is an error, the CH-th word completes and publishes it.
   task automatic model_edge(input bit v, input bit s, input logic [W-1:0] d);
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (v) begin
         if (s) begin
            m_err = in_frame;
            part.delete();
            part.push_back(d);
            in_frame = 1'b1;
         end else if (!in_frame) begin
            m_err = 1'b1;
         end else begin
            part.push_back(d);
            if (part.size() == CH) begin
               for (int k = 0; k < CH; k++) m_ch[k*W +: W] = part[k];
               m_fv = 1'b1;
               part.delete();
               in_frame = 1'b0;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("o_ch",          bus.o_ch,          m_ch);
      check("o_frame_valid", bus.o_frame_valid, m_fv);
      check("o_err",         bus.o_err,         m_err);
      check("o_busy",        bus.o_busy,        in_frame);
      check("o_sel",         bus.o_sel,         in_frame ? part.size() : 0);
      check("fv_err_excl",   bus.o_frame_valid & bus.o_err, 1'b0);
   endtask

   task automatic step(input bit v, input bit s, input logic [W-1:0] d);
      @(negedge clk);
      bus.i_valid = v;
      bus.i_sync  = s;
      bus.i_data  = d;
      @(posedge clk);
      model_edge(v, s, d);
      #1 compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom));
   endtask

   task automatic frame(input logic [W-1:0] base, input int max_gap);
      for (int k = 0; k < CH; k++) begin
         step(1'b1, k == 0, base + W'(k));
         if (max_gap > 0 && k < CH - 1) idle(1 + $urandom_range(max_gap - 1));
      end
   endtask

   initial begin
      bus.i_valid = 1'b0;
      bus.i_sync  = 1'b0;
      bus.i_data  = '0;
      rst = 1'b1;
      model_reset();
      #12 compare_all();
      @(negedge clk) rst = 1'b0;
      idle(2);

      // Basic frame 11,22,33,44
      step(1'b1, 1'b1, 8'h11);
      step(1'b1, 1'b0, 8'h22);
      step(1'b1, 1'b0, 8'h33);
      step(1'b1, 1'b0, 8'h44);
      check("tp1_ch", bus.o_ch, 32'h44332211);
      check("tp1_fv", bus.o_frame_valid, 1'b1);
      idle(2);

      // Same frame with idle gaps of 1..3 cycles
      step(1'b1, 1'b1, 8'h11);
      idle(1);
      step(1'b1, 1'b0, 8'h22);
      idle(3);
      step(1'b1, 1'b0, 8'h33);
      idle(2);
      step(1'b1, 1'b0, 8'h44);
      check("tp2_ch", bus.o_ch, 32'h44332211);
      idle(2);

      // Early sync discards AA/BB
      step(1'b1, 1'b1, 8'hAA);
      step(1'b1, 1'b0, 8'hBB);
      step(1'b1, 1'b1, 8'h01);
      check("tp3_err", bus.o_err, 1'b1);
      step(1'b1, 1'b0, 8'h02);
      step(1'b1, 1'b0, 8'h03);
      step(1'b1, 1'b0, 8'h04);
      check("tp3_ch", bus.o_ch, 32'h04030201);
      idle(1);

      // Stray words while idle
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'($urandom));
      frame(8'h31, 0);
      idle(1);

      // Back-to-back frames
      frame(8'h10, 0);
      check("tp5_ch_a", bus.o_ch, 32'h13121110);
      frame(8'h20, 0);
      check("tp5_ch_b", bus.o_ch, 32'h23222120);
      idle(2);

      // Asynchronous reset mid-frame
      step(1'b1, 1'b1, 8'h55);
      step(1'b1, 1'b0, 8'h66);
      #2 rst = 1'b1;
      #1;
      check("arst_ch",   bus.o_ch, '0);
      check("arst_sel",  bus.o_sel, '0);
      check("arst_busy", bus.o_busy, 1'b0);
      check("arst_fv",   bus.o_frame_valid, 1'b0);
      check("arst_err",  bus.o_err, 1'b0);
      model_reset();
      @(negedge clk);
      bus.i_valid = 1'b0;
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1 compare_all();
      frame(8'h71, 2);
      check("arst_frame", bus.o_ch, 32'h74737271);
      idle(1);

      // Random traffic, mostly well-formed with occasional early syncs and strays
      for (int i = 0; i < 600; i++) begin
         bit v, s;
         v = ($urandom_range(9) < 7);
         s = in_frame ? ($urandom_range(11) == 0) : ($urandom_range(5) != 0);
         step(v, s, W'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
